// File: rtl/pipelined_array_divider_stage.sv
// -----------------------------------------------------------------------------
// pipelined_array_divider_stage
//
// Purely combinational slice of the restoring array divider. Resolves
// QUOTIENT_PER_STAGE quotient bits by feeding the next dividend bits, MSB
// first, into the running partial remainder and subtracting the divisor
// whenever it fits.
//
// Ports:
//   rem_i           partial remainder entering this slice
//   dividend_bits_i dividend bits consumed by this slice, MSB first
//   divisor_i       unsigned divisor
//   rem_o           partial remainder leaving this slice
//   quotient_bits_o quotient bits resolved by this slice, MSB first
// -----------------------------------------------------------------------------
module pipelined_array_divider_stage #(
    parameter int DATA_WIDTH         = 16,
    parameter int QUOTIENT_PER_STAGE = 4
) (
    input  logic [DATA_WIDTH-1:0]         rem_i,
    input  logic [QUOTIENT_PER_STAGE-1:0] dividend_bits_i,
    input  logic [DATA_WIDTH-1:0]         divisor_i,
    output logic [DATA_WIDTH-1:0]         rem_o,
    output logic [QUOTIENT_PER_STAGE-1:0] quotient_bits_o
);

    logic [DATA_WIDTH:0]   w_trial;
    logic [DATA_WIDTH-1:0] w_rem;

    // One restoring step per quotient bit. The trial value is one bit wider
    // than the remainder so the compare against the divisor never overflows.
    // A zero divisor always "fits", so the quotient saturates to all ones and
    // the remainder simply shifts the dividend through, with no special case.
    always_comb begin
        w_rem           = rem_i;
        w_trial         = '0;
        quotient_bits_o = '0;
        for (int i = QUOTIENT_PER_STAGE - 1; i >= 0; i--) begin
            w_trial = {w_rem, dividend_bits_i[i]};
            if (w_trial >= {1'b0, divisor_i}) begin
                w_trial            = w_trial - {1'b0, divisor_i};
                quotient_bits_o[i] = 1'b1;
            end
            w_rem = w_trial[DATA_WIDTH-1:0];
        end
        rem_o = w_rem;
    end

endmodule

// File: rtl/pipelined_array_divider.sv
// -----------------------------------------------------------------------------
// pipelined_array_divider
//
// Pipelined unsigned restoring array divider. Splits the DATA_WIDTH quotient
// bits evenly over PIPELINE_DEPTH registered stages; one new operation may be
// accepted on every enabled clock edge. The last stage register drives the
// outputs directly. Data is not gated by valid; consumers qualify with
// data_valid_o.
//
// Ports:
//   clk_i            clock
//   rst_n_i          asynchronous active-low reset, clears every stage
//   clk_en_i         pipeline advance enable; all registers hold when low
//   dividend_i       unsigned dividend
//   divisor_i        unsigned divisor
//   data_valid_i     operands valid this cycle
//   quotient_o       quotient (all ones on divide by zero)
//   remainder_o      remainder (dividend on divide by zero)
//   divide_by_zero_o divisor was zero for this result
//   data_valid_o     outputs valid this cycle
// -----------------------------------------------------------------------------
module pipelined_array_divider #(
    parameter int DATA_WIDTH     = 16,
    parameter int PIPELINE_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clk_en_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    input  logic                  data_valid_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o
);

    // Guarded so an illegal depth of zero still elaborates far enough to
    // reach the legality check below instead of dividing by zero here.
    localparam int SAFE_DEPTH         = (PIPELINE_DEPTH >= 1) ? PIPELINE_DEPTH : 1;
    localparam int QUOTIENT_PER_STAGE = DATA_WIDTH / SAFE_DEPTH;

    // Reject widths and depths that cannot split the quotient evenly.
    if (DATA_WIDTH < 2) begin : g_badWidth
        $error("pipelined_array_divider: DATA_WIDTH must be at least 2");
    end
    if (PIPELINE_DEPTH < 1 || PIPELINE_DEPTH > DATA_WIDTH ||
        (DATA_WIDTH % SAFE_DEPTH) != 0) begin : g_badDepth
        $error("pipelined_array_divider: PIPELINE_DEPTH must be in 1..DATA_WIDTH and divide it");
    end

    // Stage registers.
    logic [DATA_WIDTH-1:0] r_divisor  [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0] r_dividend [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0] r_rem      [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0] r_quot     [PIPELINE_DEPTH];
    logic                  r_dbz      [PIPELINE_DEPTH];
    logic                  r_valid    [PIPELINE_DEPTH];

    // Per-stage combinational inputs and results.
    logic [DATA_WIDTH-1:0]         w_divisorIn    [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_dividendIn   [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_remIn        [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_quotIn       [PIPELINE_DEPTH];
    logic                          w_dbzIn        [PIPELINE_DEPTH];
    logic                          w_validIn      [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_remNext      [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_quotNext     [PIPELINE_DEPTH];
    logic [DATA_WIDTH-1:0]         w_dividendNext [PIPELINE_DEPTH];
    logic [QUOTIENT_PER_STAGE-1:0] w_qBits        [PIPELINE_DEPTH];

    for (genvar k = 0; k < PIPELINE_DEPTH; k++) begin : g_stage
        // Stage 0 starts from the ports with a zero remainder and empty
        // quotient; later stages pick up where the previous register left off.
        // The divide-by-zero flag is decided once here and only carried after.
        if (k == 0) begin : g_first
            assign w_divisorIn[k]  = divisor_i;
            assign w_dividendIn[k] = dividend_i;
            assign w_remIn[k]      = '0;
            assign w_quotIn[k]     = '0;
            assign w_dbzIn[k]      = (divisor_i == '0);
            assign w_validIn[k]    = data_valid_i;
        end else begin : g_rest
            assign w_divisorIn[k]  = r_divisor[k-1];
            assign w_dividendIn[k] = r_dividend[k-1];
            assign w_remIn[k]      = r_rem[k-1];
            assign w_quotIn[k]     = r_quot[k-1];
            assign w_dbzIn[k]      = r_dbz[k-1];
            assign w_validIn[k]    = r_valid[k-1];
        end

        // The unconsumed dividend bits are kept MSB-aligned, so every stage
        // reads its slice from the top and shifts the rest up for the next.
        pipelined_array_divider_stage #(
            .DATA_WIDTH         (DATA_WIDTH),
            .QUOTIENT_PER_STAGE (QUOTIENT_PER_STAGE)
        ) u_stage (
            .rem_i           (w_remIn[k]),
            .dividend_bits_i (w_dividendIn[k][DATA_WIDTH-1 -: QUOTIENT_PER_STAGE]),
            .divisor_i       (w_divisorIn[k]),
            .rem_o           (w_remNext[k]),
            .quotient_bits_o (w_qBits[k])
        );

        // New quotient bits enter at the LSB end; earlier bits move up.
        assign w_dividendNext[k] = w_dividendIn[k] << QUOTIENT_PER_STAGE;
        assign w_quotNext[k]     = (w_quotIn[k] << QUOTIENT_PER_STAGE) |
                                   DATA_WIDTH'(w_qBits[k]);
    end

    // All pipeline state advances together on an enabled edge and holds
    // otherwise; reset discards every in-flight operation, valid bits included.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                r_divisor[k]  <= '0;
                r_dividend[k] <= '0;
                r_rem[k]      <= '0;
                r_quot[k]     <= '0;
                r_dbz[k]      <= 1'b0;
                r_valid[k]    <= 1'b0;
            end
        end else if (clk_en_i) begin
            for (int k = 0; k < PIPELINE_DEPTH; k++) begin
                r_divisor[k]  <= w_divisorIn[k];
                r_dividend[k] <= w_dividendNext[k];
                r_rem[k]      <= w_remNext[k];
                r_quot[k]     <= w_quotNext[k];
                r_dbz[k]      <= w_dbzIn[k];
                r_valid[k]    <= w_validIn[k];
            end
        end
    end

    assign quotient_o       = r_quot[PIPELINE_DEPTH-1];
    assign remainder_o      = r_rem[PIPELINE_DEPTH-1];
    assign divide_by_zero_o = r_dbz[PIPELINE_DEPTH-1];
    assign data_valid_o     = r_valid[PIPELINE_DEPTH-1];

endmodule

// File: tb/tb_pipelined_array_divider.sv
// -----------------------------------------------------------------------------
// tb_pipelined_array_divider
//
// Drives a 16-bit depth-4 divider from a table of hand-computed vectors
// (including a clock-enable stall and a mid-flight asynchronous reset) and
// three 8-bit dividers of depth 1, 2 and 8 with every operand pair. Expected
// results go into per-DUT queues when driven and are compared, together with
// the enabled-edge latency, when each DUT raises data_valid_o.
// -----------------------------------------------------------------------------
module tb_pipelined_array_divider;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          stamp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        clkEn;
    logic        validIn;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbzOut;
    logic        validOut;

    logic       clkEn8;
    logic       valid8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] q8     [3];
    logic [7:0] r8     [3];
    logic       dbz8   [3];
    logic       vOut8  [3];

    int   checks = 0;
    int   errors = 0;
    int   enCount = 0;
    int   cyc8 = 0;
    logic lastEnMain = 1'b0;
    logic lastEn8 = 1'b0;

    exp_t sbMain[$];
    exp_t sbD1[$];
    exp_t sbD2[$];
    exp_t sbD8[$];
    exp_t eMain;
    exp_t e1;
    exp_t e2;
    exp_t e8;

    vec_t vecs[9];

    always #5 clk = ~clk;

    pipelined_array_divider #(.DATA_WIDTH(16), .PIPELINE_DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_n_i          (rstN),
        .clk_en_i         (clkEn),
        .dividend_i       (dividend),
        .divisor_i        (divisor),
        .data_valid_i     (validIn),
        .quotient_o       (quotient),
        .remainder_o      (remainder),
        .divide_by_zero_o (dbzOut),
        .data_valid_o     (validOut)
    );

    pipelined_array_divider #(.DATA_WIDTH(8), .PIPELINE_DEPTH(1)) dut8d1 (
        .clk_i (clk), .rst_n_i (rstN), .clk_en_i (clkEn8),
        .dividend_i (a8), .divisor_i (b8), .data_valid_i (valid8),
        .quotient_o (q8[0]), .remainder_o (r8[0]),
        .divide_by_zero_o (dbz8[0]), .data_valid_o (vOut8[0])
    );

    pipelined_array_divider #(.DATA_WIDTH(8), .PIPELINE_DEPTH(2)) dut8d2 (
        .clk_i (clk), .rst_n_i (rstN), .clk_en_i (clkEn8),
        .dividend_i (a8), .divisor_i (b8), .data_valid_i (valid8),
        .quotient_o (q8[1]), .remainder_o (r8[1]),
        .divide_by_zero_o (dbz8[1]), .data_valid_o (vOut8[1])
    );

    pipelined_array_divider #(.DATA_WIDTH(8), .PIPELINE_DEPTH(8)) dut8d8 (
        .clk_i (clk), .rst_n_i (rstN), .clk_en_i (clkEn8),
        .dividend_i (a8), .divisor_i (b8), .data_valid_i (valid8),
        .quotient_o (q8[2]), .remainder_o (r8[2]),
        .divide_by_zero_o (dbz8[2]), .data_valid_o (vOut8[2])
    );

    // Count only edges that actually advance each pipeline.
    always @(posedge clk) begin
        lastEnMain = clkEn && rstN;
        lastEn8    = clkEn8 && rstN;
        if (lastEnMain) enCount++;
        if (lastEn8) cyc8++;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: actual=valid required=no pending result", name);
    endtask

    // Reference division with the saturating divide-by-zero behaviour.
    function automatic exp_t refDiv8(input int a, input int b, input int stamp);
        exp_t e;
        e.stamp = stamp;
        e.dbz   = (b == 0);
        e.q     = (b == 0) ? 16'h00FF : 16'(a / b);
        e.r     = (b == 0) ? 16'(a) : 16'(a % b);
        return e;
    endfunction

    // Scoreboard monitors: compare after each enabled edge that shows valid.
    always @(negedge clk) begin
        if (lastEnMain && validOut) begin
            if (sbMain.size() == 0) reportUnexpected("mainSpurious");
            else begin
                eMain = sbMain.pop_front();
                checkOutput("mainQuotient", quotient, eMain.q);
                checkOutput("mainRemainder", remainder, eMain.r);
                checkOutput("mainDbz", dbzOut, eMain.dbz);
                checkOutput("mainLatency", enCount - eMain.stamp, 4);
            end
        end
    end

    always @(negedge clk) begin
        if (lastEn8 && vOut8[0]) begin
            if (sbD1.size() == 0) reportUnexpected("d1Spurious");
            else begin
                e1 = sbD1.pop_front();
                checkOutput("d1Quotient", q8[0], e1.q);
                checkOutput("d1Remainder", r8[0], e1.r);
                checkOutput("d1Dbz", dbz8[0], e1.dbz);
                checkOutput("d1Latency", cyc8 - e1.stamp, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (lastEn8 && vOut8[1]) begin
            if (sbD2.size() == 0) reportUnexpected("d2Spurious");
            else begin
                e2 = sbD2.pop_front();
                checkOutput("d2Quotient", q8[1], e2.q);
                checkOutput("d2Remainder", r8[1], e2.r);
                checkOutput("d2Dbz", dbz8[1], e2.dbz);
                checkOutput("d2Latency", cyc8 - e2.stamp, 2);
            end
        end
    end

    always @(negedge clk) begin
        if (lastEn8 && vOut8[2]) begin
            if (sbD8.size() == 0) reportUnexpected("d8Spurious");
            else begin
                e8 = sbD8.pop_front();
                checkOutput("d8Quotient", q8[2], e8.q);
                checkOutput("d8Remainder", r8[2], e8.r);
                checkOutput("d8Dbz", dbz8[2], e8.dbz);
                checkOutput("d8Latency", cyc8 - e8.stamp, 8);
            end
        end
    end

    // Drive one operand pair just after an edge; the next enabled edge
    // samples it. Valid entries are queued with the current enabled count.
    task automatic applyStimulus(input vec_t v, input logic valid, input logic push);
        exp_t e;
        @(posedge clk);
        #1;
        dividend = v.a;
        divisor  = v.b;
        validIn  = valid;
        if (valid && push) begin
            e.q = v.q; e.r = v.r; e.dbz = v.dbz; e.stamp = enCount;
            sbMain.push_back(e);
        end
    endtask

    task automatic driveIdle();
        vec_t idle;
        idle = '{a: 16'h0, b: 16'h0, q: 16'h0, r: 16'h0, dbz: 1'b0};
        applyStimulus(idle, 1'b0, 1'b0);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((sbMain.size() + sbD1.size() + sbD2.size() + sbD8.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("drainPending", sbMain.size() + sbD1.size() + sbD2.size() + sbD8.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{a: 16'd100,   b: 16'd7,   q: 16'd14,     r: 16'd2, dbz: 1'b0};
        vecs[1] = '{a: 16'hFFFF,  b: 16'd1,   q: 16'hFFFF,   r: 16'd0, dbz: 1'b0};
        vecs[2] = '{a: 16'd3,     b: 16'd10,  q: 16'd0,      r: 16'd3, dbz: 1'b0};
        vecs[3] = '{a: 16'd5,     b: 16'd0,   q: 16'hFFFF,   r: 16'd5, dbz: 1'b1};
        vecs[4] = '{a: 16'd1000,  b: 16'd3,   q: 16'd333,    r: 16'd1, dbz: 1'b0};
        vecs[5] = '{a: 16'd65535, b: 16'd255, q: 16'd257,    r: 16'd0, dbz: 1'b0};
        vecs[6] = '{a: 16'd12,    b: 16'd12,  q: 16'd1,      r: 16'd0, dbz: 1'b0};
        vecs[7] = '{a: 16'd0,     b: 16'd9,   q: 16'd0,      r: 16'd0, dbz: 1'b0};
        vecs[8] = '{a: 16'd9,     b: 16'd2,   q: 16'd4,      r: 16'd1, dbz: 1'b0};

        rstN = 1'b0; clkEn = 1'b1; validIn = 1'b0; dividend = '0; divisor = '0;
        clkEn8 = 1'b1; valid8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("resetQuotient", quotient, 0);
        checkOutput("resetRemainder", remainder, 0);
        checkOutput("resetDbz", dbzOut, 0);
        checkOutput("resetValid", validOut, 0);
        rstN = 1'b1;

        $display("[TB] back-to-back table vectors");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], 1'b1, 1'b1);
        driveIdle();
        waitDrain(20);

        $display("[TB] stream with a two-cycle enable stall");
        applyStimulus(vecs[4], 1'b1, 1'b1);
        applyStimulus(vecs[5], 1'b1, 1'b1);
        @(posedge clk);
        #1;
        clkEn = 1'b0;
        dividend = vecs[6].a; divisor = vecs[6].b; validIn = 1'b1;
        sbMain.push_back('{q: vecs[6].q, r: vecs[6].r, dbz: vecs[6].dbz, stamp: enCount});
        repeat (2) @(posedge clk);
        #1;
        clkEn = 1'b1;
        applyStimulus(vecs[7], 1'b1, 1'b1);
        driveIdle();
        waitDrain(20);

        $display("[TB] asynchronous reset with operations in flight");
        applyStimulus(vecs[4], 1'b1, 1'b0);
        applyStimulus(vecs[5], 1'b1, 1'b0);
        applyStimulus(vecs[0], 1'b1, 1'b0);
        applyStimulus(vecs[1], 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rstN = 1'b0;
        sbMain.delete();
        #1;
        checkOutput("midResetQuotient", quotient, 0);
        checkOutput("midResetRemainder", remainder, 0);
        checkOutput("midResetDbz", dbzOut, 0);
        checkOutput("midResetValid", validOut, 0);
        validIn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rstN = 1'b1;
        repeat (6) driveIdle();
        applyStimulus(vecs[8], 1'b1, 1'b1);
        driveIdle();
        waitDrain(20);

        $display("[TB] 8-bit sweep over every operand pair");
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                @(posedge clk);
                #1;
                a8 = 8'(a); b8 = 8'(b); valid8 = 1'b1;
                sbD1.push_back(refDiv8(a, b, cyc8));
                sbD2.push_back(refDiv8(a, b, cyc8));
                sbD8.push_back(refDiv8(a, b, cyc8));
            end
        end
        @(posedge clk);
        #1;
        valid8 = 1'b0;
        waitDrain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
